match_run_counter: RTL and testbench

- Downstream consumer of the sequence-detector FSM's z output.
- Counts detector matches (each new assertion of z), measures the length of the current z-high run and tracks the longest run seen.
- Outputs drive board LEDs / seven-segment display logic.
- Runs on the same clock as the detector, so z needs no synchronizer.

---
 rtl/match_run_counter.sv | 66 ++++++
 tb/tb_match_run_counter.sv | 118 +++++++++++
 2 files changed

// File: rtl/match_run_counter.sv
// match_run_counter: counts detector matches, measures the current z-high run and tracks the longest run.
module match_run_counter #(
  parameter int COUNT_WIDTH = 8,
  parameter int RUN_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   z,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] match_count,
  output logic [RUN_WIDTH-1:0]   run_len,
  output logic [RUN_WIDTH-1:0]   max_run,
  output logic                   in_run,
  output logic                   match_pulse,
  output logic                   overflow
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] match_count_q, match_count_d;
  logic [RUN_WIDTH-1:0]   run_len_q, run_len_d, max_run_q, max_run_d;
  logic                   match_pulse_q, match_pulse_d, overflow_q, overflow_d;
  logic                   start, cnt_sat;
  assign start   = (state_q == IDLE) && z;
  assign cnt_sat = &match_count_q;
  always_comb begin
    state_d       = z ? RUN : IDLE;
    match_count_d = (start && !cnt_sat) ? match_count_q + COUNT_WIDTH'(1) : match_count_q;
    run_len_d     = start ? RUN_WIDTH'(1)
                  : (state_q == RUN && z && !(&run_len_q)) ? run_len_q + RUN_WIDTH'(1)
                  : run_len_q;
    max_run_d     = (run_len_d > max_run_q) ? run_len_d : max_run_q;
    match_pulse_d = start;
    overflow_d    = overflow_q | (start && cnt_sat);
    if (clear) begin
      state_d       = IDLE;
      match_count_d = '0;
      run_len_d     = '0;
      max_run_d     = '0;
      match_pulse_d = 1'b0;
      overflow_d    = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      match_count_q <= '0;
      run_len_q     <= '0;
      max_run_q     <= '0;
      match_pulse_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_count_q <= match_count_d;
      run_len_q     <= run_len_d;
      max_run_q     <= max_run_d;
      match_pulse_q <= match_pulse_d;
      overflow_q    <= overflow_d;
    end
  end
  assign match_count = match_count_q;
  assign run_len     = run_len_q;
  assign max_run     = max_run_q;
  assign in_run      = (state_q == RUN);
  assign match_pulse = match_pulse_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_match_run_counter.sv
// tb_match_run_counter: table-driven and hand-sequenced checks of match_run_counter.
module tb_match_run_counter;
  logic       clk = 1'b0, reset = 1'b1, z = 1'b0, clear = 1'b0;
  logic [7:0] match_count;
  logic [3:0] run_len, max_run;
  logic       in_run, match_pulse, overflow;
  int         n_run = 0, n_fail = 0;
  typedef struct {
    logic       z, clr;
    logic [7:0] mc;
    logic [3:0] rl, mr;
    logic       ir, mp, ov;
  } vec_t;
  vec_t tv[$];
  match_run_counter #(.COUNT_WIDTH(8), .RUN_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .z(z), .clear(clear),
    .match_count(match_count), .run_len(run_len), .max_run(max_run),
    .in_run(in_run), .match_pulse(match_pulse), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic add(input logic zz, cc, input logic [7:0] mc, input logic [3:0] rl, mr,
                     input logic ir, mp, ov);
    vec_t v;
    v.z = zz; v.clr = cc; v.mc = mc; v.rl = rl; v.mr = mr; v.ir = ir; v.mp = mp; v.ov = ov;
    tv.push_back(v);
  endtask
  task automatic chk(input string name, input logic [7:0] mc, input logic [3:0] rl, mr,
                     input logic ir, mp, ov);
    logic [18:0] act, exp;
    act = {match_count, run_len, max_run, in_run, match_pulse, overflow};
    exp = {mc, rl, mr, ir, mp, ov};
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got mc=%0d rl=%0d mr=%0d in=%b mp=%b ov=%b, want mc=%0d rl=%0d mr=%0d in=%b mp=%b ov=%b",
               name, match_count, run_len, max_run, in_run, match_pulse, overflow, mc, rl, mr, ir, mp, ov);
    end
  endtask
  task automatic step(input logic zz, cc);
    @(negedge clk);
    z = zz;
    clear = cc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int mc_e;
    // columns: z clear | match_count run_len max_run in_run match_pulse overflow
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 0);
    add(1, 0, 1, 2, 2, 1, 0, 0);
    add(1, 0, 1, 3, 3, 1, 0, 0);
    add(0, 0, 1, 3, 3, 0, 0, 0);
    add(0, 0, 1, 3, 3, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 0);
    add(1, 0, 1, 2, 2, 1, 0, 0);
    add(0, 0, 1, 2, 2, 0, 0, 0);
    add(1, 0, 2, 1, 2, 1, 1, 0);
    add(1, 0, 2, 2, 2, 1, 0, 0);
    add(1, 0, 2, 3, 3, 1, 0, 0);
    add(1, 0, 2, 4, 4, 1, 0, 0);
    add(1, 0, 2, 5, 5, 1, 0, 0);
    add(0, 0, 2, 5, 5, 0, 0, 0);
    add(0, 0, 2, 5, 5, 0, 0, 0);
    add(1, 0, 3, 1, 5, 1, 1, 0);
    add(0, 0, 3, 1, 5, 0, 0, 0);
    add(1, 0, 4, 1, 5, 1, 1, 0);
    add(1, 0, 4, 2, 5, 1, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 1, 0);
    add(1, 0, 1, 2, 2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    #2;
    chk("reset_held", 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_released", 0, 0, 0, 0, 0, 0);
    foreach (tv[i]) begin
      step(tv[i].z, tv[i].clr);
      chk($sformatf("vec%0d", i), tv[i].mc, tv[i].rl, tv[i].mr, tv[i].ir, tv[i].mp, tv[i].ov);
    end
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      chk($sformatf("run_sat%0d", i), 1, (i < 15) ? 4'(i + 1) : 4'd15,
          (i < 15) ? 4'(i + 1) : 4'd15, 1, (i == 0), 0);
    end
    step(0, 0);
    chk("run_sat_end", 1, 15, 15, 0, 0, 0);
    step(0, 1);
    for (int i = 0; i < 256; i++) begin
      step(1, 0);
      mc_e = (i < 255) ? i + 1 : 255;
      if (i >= 250 || i % 32 == 0)
        chk($sformatf("pulse%0d", i), 8'(mc_e), 1, 1, 1, 1, (i == 255));
      step(0, 0);
    end
    chk("cnt_sat_idle", 255, 1, 1, 0, 0, 1);
    step(1, 0);
    chk("cnt_sat_again", 255, 1, 1, 1, 1, 1);
    step(1, 0);
    chk("async_pre", 255, 2, 2, 1, 0, 1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", 0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_match", 1, 1, 1, 1, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
